// File: rtl/instr_mem_fetch.sv
// IF-stage instruction memory, valid/ready fetch.
// IMEM_LOAD_EN enables the ld_* load port.
module instr_mem_fetch #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 32,
  parameter string INIT_FILE =
    "instruction_rom_single_dp.txt",
  parameter logic [DATA_W-1:0] NOP_INSTR =
    DATA_W'(32'h00000013)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_instr,
  output logic [ADDR_W-1:0]        resp_pc,
  output logic [1:0]               resp_fault,
  output logic [31:0]              fetch_count,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_range;
  logic [1:0]        fault;
  logic              accept;

  assign word_addr  = req_addr >> 2;
  assign idx        = req_addr[IDX_W+1:2];
  assign misaligned = |req_addr[1:0];
  assign out_range  =
    word_addr >= ADDR_W'(DEPTH);
  assign fault      = {out_range, misaligned};

  assign req_ready =
    !flush && (!resp_valid || resp_ready);
  assign accept = req_valid && req_ready;

`ifdef IMEM_LOAD_EN
  always_ff @(posedge clk) begin
    if (reset_n && ld_en)
      mem[ld_addr] <= ld_data;
  end
`else
  logic unused_ld;
  assign unused_ld =
    ^{ld_en, ld_addr, ld_data};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid  <= 1'b0;
      resp_instr  <= '0;
      resp_pc     <= '0;
      resp_fault  <= '0;
      fetch_count <= '0;
    end else if (flush) begin
      resp_valid  <= 1'b0;
    end else if (accept) begin
      resp_valid  <= 1'b1;
      resp_pc     <= req_addr;
      resp_fault  <= fault;
      resp_instr  <= (|fault) ?
        NOP_INSTR : mem[idx];
      fetch_count <= fetch_count + 32'd1;
    end else if (resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed scoreboard bench for instr_mem_fetch.
// Runs in both builds; load expectations follow IMEM_LOAD_EN.
module tb_instr_mem_fetch;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_instr;
   logic [31:0] resp_pc;
   logic [1:0]  resp_fault;
   logic [31:0] fetch_count;
   logic        ld_en;
   logic [3:0]  ld_addr;
   logic [31:0] ld_data;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  fault;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [DEPTH];
   logic [31:0] cnt_mdl;
   int          errors = 0;
   int          checks = 0;

   instr_mem_fetch #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .INIT_FILE(""), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_instr(resp_instr),
      .resp_pc(resp_pc), .resp_fault(resp_fault),
      .fetch_count(fetch_count), .ld_en(ld_en),
      .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a);
      exp_t e;
      logic [31:0] w;
      w       = a >> 2;
      e.pc    = a;
      e.fault = {w >= 32'(DEPTH), a[1:0] != 2'b00};
      e.instr = (e.fault != 2'b00) ? NOP : mdl[w[3:0]];
      return e;
   endfunction

   // Called at posedge+1: score this cycle, then advance one edge.
   task automatic tick();
      exp_t e;
      #1;
      if (reset_n && resp_valid && resp_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty: observed %0d expected >0", sb.size());
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_pc", resp_pc, e.pc);
            chk("resp_instr", resp_instr, e.instr);
            chk("resp_fault", {30'd0, resp_fault}, {30'd0, e.fault});
         end
      end
      if (reset_n && req_valid && req_ready) begin
         sb.push_back(model(req_addr));
         cnt_mdl++;
      end
`ifdef IMEM_LOAD_EN
      if (reset_n && ld_en) mdl[ld_addr] = ld_data;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_instr"}, resp_instr, 32'd0);
      chk({tag, "_pc"}, resp_pc, 32'd0);
      chk({tag, "_fault"}, {30'd0, resp_fault}, 32'd0);
      chk({tag, "_count"}, fetch_count, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0;
      req_addr = '0; resp_ready = 1'b1;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      cnt_mdl = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mdl[i] = (i < 4) ? 32'h11111111 * (i + 1) : 32'hA0000000 + i;
         dut.mem[i] <= mdl[i];
      end
      @(posedge clk); #1;
      check_zero("reset");
      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // back-to-back fetches
      req_valid = 1'b1;
      req_addr = 32'd0;
      tick();
      chk("lat_valid", {31'd0, resp_valid}, 32'd1);
      chk("lat_instr", resp_instr, 32'h11111111);
      req_addr = 32'd4;  tick();
      req_addr = 32'd8;  tick();
      req_addr = 32'd12; tick();
      req_valid = 1'b0;
      tick();
      chk("b2b_count", fetch_count, 32'd4);
      chk("b2b_drained", sb.size(), 32'd0);
      chk("b2b_idle", {31'd0, resp_valid}, 32'd0);

      // stall via backpressure
      req_valid = 1'b1;
      req_addr = 32'd4;
      tick();
      resp_ready = 1'b0;
      req_addr = 32'd8;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ready", {31'd0, req_ready}, 32'd0);
         chk("stall_instr", resp_instr, 32'h22222222);
         chk("stall_pc", resp_pc, 32'd4);
         chk("stall_count", fetch_count, cnt_mdl);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("stall_resume", resp_instr, 32'h33333333);
      tick();
      chk("stall_count_end", fetch_count, 32'd6);

      // faults
      req_valid = 1'b1;
      req_addr = 32'h6;                 tick();
      req_addr = 32'(DEPTH * 4);        tick();
      req_addr = 32'(DEPTH * 4 + 2);    tick();
      req_addr = 32'h80000000;          tick();
      req_addr = 32'(DEPTH * 4 - 4);    tick();
      req_valid = 1'b0;
      tick();
      chk("fault_count", fetch_count, 32'd11);
      chk("fault_drained", sb.size(), 32'd0);

      // flush during stall
      req_valid = 1'b1;
      req_addr = 32'd8;
      tick();
      resp_ready = 1'b0;
      req_addr = 32'd0;
      flush = 1'b1;
      #1;
      chk("flush_ready", {31'd0, req_ready}, 32'd0);
      tick();
      flush = 1'b0;
      req_valid = 1'b0;
      chk("flush_valid", {31'd0, resp_valid}, 32'd0);
      chk("flush_count", fetch_count, cnt_mdl);
      if (sb.size() != 0) void'(sb.pop_front());
      resp_ready = 1'b1;
      tick();

      // load in the same cycle as a fetch of the same word
      req_valid = 1'b1;
      req_addr = 32'd20;
      ld_en = 1'b1; ld_addr = 4'd5; ld_data = 32'hDEADBEEF;
      tick();
      ld_en = 1'b0;
      chk("ld_old", resp_instr, 32'hA0000005);
      tick();
      req_valid = 1'b0;
      tick();
`ifdef IMEM_LOAD_EN
      chk("ld_new", mdl[5], 32'hDEADBEEF);
`endif

      // async reset mid-cycle, then reach count 7
      #2 reset_n = 1'b0;
      #1;
      check_zero("rst1");
      sb.delete();
      cnt_mdl = '0;
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         req_addr = 32'(i * 4);
         tick();
      end
      req_valid = 1'b0;
      resp_ready = 1'b0;
      chk("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
      chk("pre_rst_count", fetch_count, 32'd7);
      #2 reset_n = 1'b0;
      #1;
      check_zero("rst2");
      sb.delete();
      cnt_mdl = '0;

      // loads ignored in reset; no response after release until accept
      resp_ready = 1'b1;
      ld_en = 1'b1; ld_addr = 4'd6; ld_data = 32'hBAD0BAD0;
      tick();
      ld_en = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      tick();
      chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);
      req_valid = 1'b1;
      req_addr = 32'd24;
      tick();
      req_valid = 1'b0;
      chk("rst_ld_ignored", resp_instr, 32'hA0000006);
      tick();
      chk("final_count", fetch_count, 32'd1);
      chk("final_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
